// File: rtl/sobel_window_buffer.sv
// Line-buffered 3x3 window generator feeding the Sobel operator.
// Emits one registered neighbourhood per interior pixel of a raster-order grey stream.
module sobel_window_buffer #(
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned BITS_FOR_INDEX = 10,
    parameter int unsigned DATA_WIDTH     = 8
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [DATA_WIDTH-1:0]       in_pixel,
    output logic                        win_valid,
    output logic [9*DATA_WIDTH-1:0]     win_pix,
    output logic [BITS_FOR_INDEX-1:0]   out_row,
    output logic [BITS_FOR_INDEX-1:0]   out_col,
    output logic                        frame_done
);

    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned IW  = BITS_FOR_INDEX;
    localparam int unsigned CW  = 3 * DATA_WIDTH;
    localparam int unsigned CAW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0]   row;
    logic [IW-1:0]   col;
    logic [IW-1:0]   pos_row;
    logic [IW-1:0]   pos_col;
    logic [CAW-1:0]  addr;
    logic [DW-1:0]   lb1 [WIDTH];
    logic [DW-1:0]   lb2 [WIDTH];
    logic [CW-1:0]   col_a;
    logic [CW-1:0]   col_b;
    logic [CW-1:0]   vec;
    logic [9*DW-1:0] win_next;
    logic            last_col;
    logic            last_row;
    logic            emit;

    // Position of the pixel being accepted; in_sof forces it to (0,0).
    always_comb begin
        pos_row  = in_sof ? '0 : row;
        pos_col  = in_sof ? '0 : col;
        addr     = CAW'(pos_col);
        vec      = {in_pixel, lb1[addr], lb2[addr]};
        last_col = (pos_col == IW'(WIDTH - 1));
        last_row = (pos_row == IW'(HEIGHT - 1));
        emit     = in_valid && (pos_row >= IW'(2)) && (pos_col >= IW'(2));
        win_next = '0;
        for (int i = 0; i < 3; i++) begin
            win_next[DW*(3*i)   +: DW] = col_a[DW*i +: DW];
            win_next[DW*(3*i+1) +: DW] = col_b[DW*i +: DW];
            win_next[DW*(3*i+2) +: DW] = vec[DW*i +: DW];
        end
    end

    // Line memories are never reset; stale contents are masked by the counters.
    always_ff @(posedge HCLK) begin
        if (in_valid) begin
            lb2[addr] <= lb1[addr];
            lb1[addr] <= in_pixel;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            row        <= '0;
            col        <= '0;
            col_a      <= '0;
            col_b      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_pix    <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && last_row && last_col;
            if (in_valid) begin
                col_a <= col_b;
                col_b <= vec;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : pos_row + IW'(1);
                end else begin
                    col <= pos_col + IW'(1);
                    row <= pos_row;
                end
            end
            if (emit) begin
                win_pix <= win_next;
                out_row <= pos_row - IW'(1);
                out_col <= pos_col - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 5x4 image with an image-array reference model.
module tb_sobel_window_buffer;

    localparam int W = 5;
    localparam int H = 4;

    logic        HCLK     = 1'b0;
    logic        HRESETn  = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof   = 1'b0;
    logic [7:0]  in_pixel = 8'd0;
    logic        win_valid;
    logic [71:0] win_pix;
    logic [9:0]  out_row;
    logic [9:0]  out_col;
    logic        frame_done;

    always #5 HCLK = ~HCLK;

    sobel_window_buffer #(
        .WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(10), .DATA_WIDTH(8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .win_valid(win_valid), .win_pix(win_pix),
        .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_v   = 1'b0;
    logic        exp_fd  = 1'b0;
    logic [9:0]  exp_row = '0;
    logic [9:0]  exp_col = '0;
    logic [71:0] exp_pix = '0;
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;

    int          n_win, n_fd;
    logic [71:0] first_pix, last_pix;
    logic [9:0]  first_row, first_col, last_row, last_col;
    logic        last_fd;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare last edge's outputs, then drive the next cycle and predict its result.
    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] p);
        int r, c;
        @(negedge HCLK);
        check("win_valid", 72'(win_valid), 72'(exp_v));
        check("frame_done", 72'(frame_done), 72'(exp_fd));
        check("out_row", 72'(out_row), 72'(exp_row));
        check("out_col", 72'(out_col), 72'(exp_col));
        check("win_pix", win_pix, exp_pix);
        if (win_valid) begin
            if (n_win == 0) begin
                first_pix = win_pix; first_row = out_row; first_col = out_col;
            end
            last_pix = win_pix; last_row = out_row; last_col = out_col; last_fd = frame_done;
            n_win++;
        end
        if (frame_done) n_fd++;

        HRESETn = rst; in_valid = v; in_sof = s; in_pixel = p;
        exp_v = 1'b0; exp_fd = 1'b0;
        if (rst) begin
            exp_row = '0; exp_col = '0; exp_pix = '0; mr = 0; mc = 0;
        end else if (v) begin
            r = s ? 0 : mr;
            c = s ? 0 : mc;
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_v   = 1'b1;
                exp_row = 10'(r - 1);
                exp_col = 10'(c - 1);
                exp_fd  = (r == H - 1) && (c == W - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_pix[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
            end
            if (c == W - 1) begin
                mc = 0;
                mr = (r == H - 1) ? 0 : r + 1;
            end else begin
                mc = c + 1;
                mr = r;
            end
        end
    endtask

    task automatic clr();
        n_win = 0; n_fd = 0; last_fd = 1'b0;
    endtask

    task automatic frame(input int base, input bit sof, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                step(0, 1, sof && r == 0 && c == 0, 8'(base + 10*r + c));
                if (gaps) step(0, 0, 0, 8'd0);
            end
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);
    endtask

    localparam logic [71:0] WIN_FIRST  = 72'h16_15_14_0c_0b_0a_02_01_00;
    localparam logic [71:0] WIN_LAST   = 72'h22_21_20_18_17_16_0e_0d_0c;
    localparam logic [71:0] WIN_FIRST2 = 72'h7a_79_78_70_6f_6e_66_65_64;

    initial begin
        step(1, 0, 0, 8'd0);
        step(1, 0, 0, 8'd0);

        // basic back-to-back frame
        clr();
        frame(0, 1, 0);
        check("basic_count", 72'(n_win), 72'd6);
        check("basic_first_row", 72'(first_row), 72'd1);
        check("basic_first_col", 72'(first_col), 72'd1);
        check("basic_first_pix", first_pix, WIN_FIRST);
        check("basic_last_row", 72'(last_row), 72'd2);
        check("basic_last_col", 72'(last_col), 72'd3);
        check("basic_last_pix", last_pix, WIN_LAST);
        check("basic_last_fd", 72'(last_fd), 72'd1);
        check("basic_fd_count", 72'(n_fd), 72'd1);

        // in_valid toggling every other cycle
        clr();
        frame(0, 1, 1);
        check("gaps_count", 72'(n_win), 72'd6);
        check("gaps_first_pix", first_pix, WIN_FIRST);
        check("gaps_last_pix", last_pix, WIN_LAST);
        check("gaps_fd_count", 72'(n_fd), 72'd1);

        // wrapped second frame without in_sof
        clr();
        frame(100, 0, 0);
        check("wrap_count", 72'(n_win), 72'd6);
        check("wrap_first_row", 72'(first_row), 72'd1);
        check("wrap_first_pix", first_pix, WIN_FIRST2);
        check("wrap_fd_count", 72'(n_fd), 72'd1);

        // in_sof on counter position (2,3)
        clr();
        for (int k = 0; k < 13; k++) step(0, 1, 0, 8'(50 + k));
        frame(0, 1, 0);
        check("midsof_count", 72'(n_win), 72'd7);
        check("midsof_fd_count", 72'(n_fd), 72'd1);
        check("midsof_last_pix", last_pix, WIN_LAST);

        // in_sof on what would be the final pixel
        clr();
        for (int k = 0; k < W*H - 1; k++) step(0, 1, 0, 8'(10*(k / W) + k % W));
        step(0, 1, 1, 8'd99);
        step(0, 0, 0, 8'd0);
        check("lastsof_count", 72'(n_win), 72'd5);
        check("lastsof_fd_count", 72'(n_fd), 72'd0);

        // reset while pixel (2,3) is presented
        clr();
        for (int k = 0; k < 13; k++) step(0, 1, k == 0, 8'(10*(k / W) + k % W));
        step(1, 1, 0, 8'd23);
        step(0, 0, 0, 8'd0);
        check("rst_valid", 72'(win_valid), 72'd0);
        check("rst_fd", 72'(frame_done), 72'd0);
        check("rst_pix", win_pix, 72'd0);
        frame(0, 0, 0);
        check("rst_count", 72'(n_win), 72'd7);
        check("rst_fd_count", 72'(n_fd), 72'd1);
        check("rst_last_pix", last_pix, WIN_LAST);

        // random pixels with random idle cycles
        clr();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < W*H; k++) begin
                step(0, 1, f == 0 && k == 0, 8'($urandom));
                if ($urandom_range(0, 1) == 1) step(0, 0, 0, 8'd0);
            end
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);
        check("rand_count", 72'(n_win), 72'd18);
        check("rand_fd_count", 72'(n_fd), 72'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
